// File: rtl/iob_tdp_fifo_ctrl_pkg.sv
// Shared constants for the TDP-RAM backed FIFO controller: default geometry,
// pointer width and threshold defaults.
package iob_tdp_fifo_ctrl_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_PTR_W     = DEF_ADDR_W + 1;
  localparam int DEF_DEPTH     = 2 ** DEF_ADDR_W;
  localparam int DEF_AFULL_TH  = 12;
  localparam int DEF_AEMPTY_TH = 2;

  function automatic int fifo_depth(input int addr_w);
    return 2 ** addr_w;
  endfunction

endpackage

// File: rtl/iob_fifo_ptr.sv
// FIFO pointer: PTR_W-bit counter with increment enable and asynchronous clear.
// The MSB acts as the wrap bit that separates full from empty.
module iob_fifo_ptr
  import iob_tdp_fifo_ctrl_pkg::*;
#(
  parameter int PTR_W = DEF_PTR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/iob_tdp_fifo_ctrl.sv
// Synchronous FIFO controller driving an external true dual-port RAM:
// port A writes, port B reads; pointers, level and flags live here.
module iob_tdp_fifo_ctrl
  import iob_tdp_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AFULL_TH  = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_full,
  input  logic              r_en,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              r_empty,
  output logic [ADDR_W:0]   level,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              ram_en_a,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              ram_en_b,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  input  logic [DATA_W-1:0] ram_q_b
);

  localparam int               PTR_W     = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AFULL_V   = PTR_W'(AFULL_TH);
  localparam logic [PTR_W-1:0] AEMPTY_V  = PTR_W'(AEMPTY_TH);
  localparam logic             AFULL_RST = (AFULL_TH == 0);

  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W-1:0] wptr_nxt, rptr_nxt, level_nxt;
  logic             wr_ok, rd_ok;
  logic             vld_p1;

  function automatic logic ptr_full(input logic [PTR_W-1:0] wp, input logic [PTR_W-1:0] rp);
    return (wp[ADDR_W] != rp[ADDR_W]) && (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]);
  endfunction

  // Accept stage: flags gate requests; RAM ports are driven combinationally
  assign wr_ok = w_en & ~w_full;
  assign rd_ok = r_en & ~r_empty;

  assign ram_en_a   = wr_ok;
  assign ram_we_a   = wr_ok;
  assign ram_addr_a = wptr[ADDR_W-1:0];
  assign ram_data_a = w_data;

  assign ram_en_b   = rd_ok;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rptr[ADDR_W-1:0];

  iob_fifo_ptr #(.PTR_W(PTR_W)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_ok),
    .ptr   (wptr)
  );

  iob_fifo_ptr #(.PTR_W(PTR_W)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_ok),
    .ptr   (rptr)
  );

  // Flags are derived from the post-edge pointers so they are valid right after the accepting edge
  assign wptr_nxt  = wptr + PTR_W'(wr_ok);
  assign rptr_nxt  = rptr + PTR_W'(rd_ok);
  assign level_nxt = wptr_nxt - rptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level        <= '0;
      w_full       <= 1'b0;
      r_empty      <= 1'b1;
      almost_full  <= AFULL_RST;
      almost_empty <= 1'b1;
      vld_p1       <= 1'b0;
    end else begin
      level        <= level_nxt;
      w_full       <= ptr_full(wptr_nxt, rptr_nxt);
      r_empty      <= (wptr_nxt == rptr_nxt);
      almost_full  <= (level_nxt >= AFULL_V);
      almost_empty <= (level_nxt <= AEMPTY_V);
      vld_p1       <= rd_ok;
    end
  end

  // Data stage: the RAM registers port B, so its output lines up with vld_p1
  assign r_valid = vld_p1;
  assign r_data  = ram_q_b;

endmodule

// File: tb/tb_iob_tdp_fifo_ctrl.sv
// Scoreboard bench for iob_tdp_fifo_ctrl wired to a behavioural TDP RAM.
module tb_iob_tdp_fifo_ctrl;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int AFULL_TH  = 12;
  localparam int AEMPTY_TH = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              w_en = 1'b0;
  logic [DATA_W-1:0] w_data = '0;
  logic              w_full;
  logic              r_en = 1'b0;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_empty;
  logic [ADDR_W:0]   level;
  logic              almost_full;
  logic              almost_empty;
  logic              ram_en_a;
  logic              ram_we_a;
  logic [ADDR_W-1:0] ram_addr_a;
  logic [DATA_W-1:0] ram_data_a;
  logic              ram_en_b;
  logic              ram_we_b;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [DATA_W-1:0] ram_q_b;

  iob_tdp_fifo_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .w_en(w_en), .w_data(w_data), .w_full(w_full),
    .r_en(r_en), .r_data(r_data), .r_valid(r_valid), .r_empty(r_empty),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
    .ram_en_a(ram_en_a), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a),
    .ram_en_b(ram_en_b), .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_q_b(ram_q_b)
  );

  always #5 clk = ~clk;

  // Behavioural true dual-port RAM, registered read, contents never reset
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en_a && ram_we_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_en_b) ram_q_b <= mem[ram_addr_b];
  end

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  logic [DATA_W-1:0] model_q [$];
  exp_t              exp_q [$];
  int                wcnt = 0;
  int                rcnt = 0;
  int                cyc = 0;
  int                tests = 0;
  int                fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    if (AFULL_TH < 0 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH > DEPTH) begin
      $display("FAIL threshold_range AFULL_TH=%0d AEMPTY_TH=%0d depth=%0d", AFULL_TH, AEMPTY_TH, DEPTH);
      $fatal(1, "threshold out of range");
    end
  end

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    model_q.delete();
    exp_q.delete();
    wcnt = 0;
    rcnt = 0;
  endfunction

  task automatic check_state();
    int sz;
    sz = model_q.size();
    chk("level", int'(level), sz);
    chk("w_full", int'(w_full), int'(sz == DEPTH));
    chk("r_empty", int'(r_empty), int'(sz == 0));
    chk("almost_full", int'(almost_full), int'(sz >= AFULL_TH));
    chk("almost_empty", int'(almost_empty), int'(sz <= AEMPTY_TH));
  endtask

  // Called at posedge+1; leaves the bench at the next posedge+1
  task automatic step(input logic we, input logic [DATA_W-1:0] wd, input logic re);
    int   sz;
    bit   wok, rok;
    exp_t e;
    w_en = we; w_data = wd; r_en = re;
    #1;
    sz  = model_q.size();
    wok = we && (sz < DEPTH);
    rok = re && (sz > 0);
    chk("ram_en_a", int'(ram_en_a), int'(wok));
    chk("ram_we_a", int'(ram_we_a), int'(wok));
    if (wok) begin
      chk("ram_addr_a", int'(ram_addr_a), wcnt % DEPTH);
      chk("ram_data_a", int'(ram_data_a), int'(wd));
    end
    chk("ram_en_b", int'(ram_en_b), int'(rok));
    if (rok) chk("ram_addr_b", int'(ram_addr_b), rcnt % DEPTH);
    chk("ram_we_b", int'(ram_we_b), 0);
    if (rok) begin
      e.data = model_q.pop_front();
      e.due  = cyc + 1;
      exp_q.push_back(e);
      rcnt++;
    end
    if (wok) begin
      model_q.push_back(wd);
      wcnt++;
    end
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b0;
    check_state();
  endtask

  task automatic drain();
    while (model_q.size() > 0) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
  endtask

  // Monitor: every r_valid must match the oldest expected word on its due cycle
  always @(negedge clk) begin
    exp_t e;
    if (r_valid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL r_valid_unexpected: got r_valid=1 data=%0h expected no read (cycle %0d)", r_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("r_data", int'(r_data), int'(e.data));
        chk("r_valid_cycle", cyc, e.due);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      tests++; fails++;
      $display("FAIL r_valid_missing: got r_valid=0 expected data %0h at cycle %0d", e.data, e.due);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] pat;
    // 1: reset and idle
    model_reset();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    check_state();
    chk("r_valid_reset", int'(r_valid), 0);
    repeat (3) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // 2: fill to full, then one dropped write
    for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(8'h10 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);

    // 3: read back to back, extra reads ignored
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    // 4: fill 8, then simultaneous traffic across the pointer wrap
    pat = 8'h40;
    for (int i = 0; i < 8; i++) begin step(1'b1, pat, 1'b0); pat++; end
    for (int i = 0; i < 40; i++) begin step(1'b1, pat, 1'b1); pat++; end
    drain();

    // 5: full plus both, then empty plus both
    for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'($urandom), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    drain();
    step(1'b1, 8'h77, 1'b1);
    drain();

    // Randomized traffic with a drifting read bias
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), DATA_W'($urandom),
           1'(($urandom_range(0, 99)) < ((i / 50) % 2 == 0 ? 35 : 65)));
    end
    drain();

    // 6: reset mid-operation with a read pending
    for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(8'hC0 + i), 1'b0);
    r_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    chk("r_valid_async_rst", int'(r_valid), 0);
    r_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_state();
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
